mux16_rr_sched: RTL and testbench

Round-robin scheduler that shares one 16:1 single-bit select mux among 16 requesters. It drives the mux `sel[3:0]`, tracks one grant at a time, and limits how long a requester may hold the mux. Requesters are released explicitly by `release` or by dropping their request. A hold-limit timeout is reported to the system. The block sits directly in front of the 16:1 mux; the mux data path itself is not part of this block.

---
 rtl/mux_sched_pkg.sv | 17 +
 rtl/mux16_rr_sched_if.sv | 22 ++
 rtl/rr_pick16.sv | 28 ++
 rtl/mux16_rr_sched.sv | 104 ++++++++++
 tb/tb_mux16_rr_sched.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_sched_pkg.sv
// Shared constants, state type and helpers for the 16-way round-robin mux scheduler.
package mux_sched_pkg;

  localparam int N     = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] sel);
    onehot      = '0;
    onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/mux16_rr_sched_if.sv
// Request/grant bundle between the requesters (master) and the scheduler (slave).
interface mux16_rr_sched_if;
  import mux_sched_pkg::*;

  logic [N-1:0]     req;
  logic             release_grant;  // the holder is finished
  logic [SEL_W-1:0] sel;
  logic [N-1:0]     grant;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output req, release_grant,
    input  sel, grant, gnt_valid, timeout
  );

  modport slave (
    input  req, release_grant,
    output sel, grant, gnt_valid, timeout
  );

endinterface

// File: rtl/rr_pick16.sv
// Rotate-priority finder: first set bit of req searching upward from ptr, modulo 16.
module rr_pick16
  import mux_sched_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] cand;

  // NOTE: every output of a combinational block gets a default up front; any
  // path that leaves one unassigned would infer a latch.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 0; k < N; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin owner of a shared 16:1 mux select, with a bounded hold time and timeout pulse.
module mux16_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  mux16_rr_sched_if.slave   bus
);

  localparam int CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_nx;
  logic [SEL_W-1:0] sel_q, sel_nx;
  logic [SEL_W-1:0] ptr_q, ptr_nx;
  logic [N-1:0]     grant_q, grant_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic             timeout_q, timeout_nx;

  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic             dropped, forced, voluntary;

  // On exit the holder moves to the back of the queue, so search from sel+1.
  assign pick_ptr  = (state_q == GRANT) ? sel_q + SEL_W'(1) : ptr_q;
  assign dropped   = !bus.req[sel_q];
  assign forced    = (cnt_q == CNT_LAST);
  assign voluntary = bus.release_grant || dropped;

  rr_pick16 u_pick (
    .req   (bus.req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_nx   = state_q;
    sel_nx     = sel_q;
    ptr_nx     = ptr_q;
    grant_nx   = grant_q;
    cnt_nx     = cnt_q;
    timeout_nx = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_nx   = pick_idx;
          grant_nx = onehot(pick_idx);
          cnt_nx   = '0;
          state_nx = GRANT;
        end
      end

      GRANT: begin
        if (voluntary || forced) begin
          ptr_nx     = pick_ptr;
          cnt_nx     = '0;
          timeout_nx = forced && !voluntary;
          if (pick_found) begin
            sel_nx   = pick_idx;
            grant_nx = onehot(pick_idx);
          end else begin
            grant_nx = '0;
            state_nx = IDLE;
          end
        end else if (cnt_q != '1) begin
          cnt_nx = cnt_q + CNT_W'(1);
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      ptr_q     <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_nx;
      sel_q     <= sel_nx;
      ptr_q     <= ptr_nx;
      grant_q   <= grant_nx;
      cnt_q     <= cnt_nx;
      timeout_q <= timeout_nx;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.grant     = grant_q;
  assign bus.gnt_valid = |grant_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Directed scenarios plus randomized traffic against a queue-free round-robin reference model.
module tb_mux16_rr_sched;

  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mux16_rr_sched_if bus ();

  mux16_rr_sched #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who holds the mux, for how many cycles so far, and the search start.
  bit          m_valid;
  int          m_sel;
  int          m_ptr;
  int          m_hold;
  bit          m_to;
  logic [15:0] m_grant;

  function automatic int rr_search(input logic [15:0] r, input int p);
    for (int k = 0; k < 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_sel   = 0;
    m_ptr   = 0;
    m_hold  = 0;
    m_to    = 1'b0;
    m_grant = '0;
  endtask

  task automatic model_step();
    int w;
    bit vol, frc;
    logic [15:0] one;
    m_to = 1'b0;
    if (!m_valid) begin
      w = rr_search(bus.req, m_ptr);
      if (w >= 0) begin
        m_valid = 1'b1;
        m_sel   = w;
        m_hold  = 1;
      end
    end else begin
      vol = bus.release_grant || !bus.req[m_sel];
      frc = (m_hold >= MAX_HOLD);
      if (vol || frc) begin
        m_to  = frc && !vol;
        m_ptr = (m_sel + 1) % 16;
        w     = rr_search(bus.req, m_ptr);
        if (w >= 0) begin
          m_sel  = w;
          m_hold = 1;
        end else begin
          m_valid = 1'b0;
        end
      end else begin
        m_hold++;
      end
    end
    one     = 16'h0001;
    m_grant = m_valid ? (one << m_sel) : 16'h0000;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    bus.req           = '0;
    bus.release_grant = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #3;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.sel !== 4'd0) $display("FAIL reset_sel: got %0d want 0", bus.sel); else n_pass++;
    n_checks++;
    if (bus.grant !== 16'h0000) $display("FAIL reset_grant: got %h want 0000", bus.grant); else n_pass++;
    n_checks++;
    if (bus.gnt_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.gnt_valid); else n_pass++;
    n_checks++;
    if (bus.timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", bus.timeout); else n_pass++;
  endtask

  task automatic test_single();
    bus.req = 16'h0008;
    tick();
    n_checks++;
    if (bus.sel !== 4'd3) $display("FAIL single_sel: got %0d want 3", bus.sel); else n_pass++;
    n_checks++;
    if (bus.grant !== 16'h0008) $display("FAIL single_grant: got %h want 0008", bus.grant); else n_pass++;
    n_checks++;
    if (bus.gnt_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", bus.gnt_valid); else n_pass++;
    bus.req           = 16'h0000;
    bus.release_grant = 1'b1;
    tick();
    bus.release_grant = 1'b0;
    n_checks++;
    if (bus.gnt_valid !== 1'b0) $display("FAIL single_release_valid: got %b want 0", bus.gnt_valid); else n_pass++;
    n_checks++;
    if (bus.sel !== 4'd3) $display("FAIL single_release_sel: got %0d want 3", bus.sel); else n_pass++;
    n_checks++;
    if (bus.timeout !== 1'b0) $display("FAIL single_release_timeout: got %b want 0", bus.timeout); else n_pass++;
  endtask

  task automatic test_rotation();
    int order [6] = '{0, 1, 15, 0, 1, 15};
    do_reset();
    bus.req = 16'h8003;
    tick();
    bus.release_grant = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (bus.sel !== 4'(order[i]) || bus.gnt_valid !== 1'b1)
        $display("FAIL rotation_%0d: got sel %0d valid %b want sel %0d valid 1", i, bus.sel, bus.gnt_valid, order[i]);
      else n_pass++;
      tick();
    end
    bus.release_grant = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    bus.req = 16'h0021;
    for (int i = 0; i < MAX_HOLD; i++) begin
      tick();
      n_checks++;
      if (bus.sel !== 4'd0 || bus.gnt_valid !== 1'b1 || bus.timeout !== 1'b0)
        $display("FAIL timeout_hold_%0d: got sel %0d valid %b to %b want sel 0 valid 1 to 0", i, bus.sel, bus.gnt_valid, bus.timeout);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (bus.sel !== 4'd5 || bus.timeout !== 1'b1)
      $display("FAIL timeout_pulse: got sel %0d to %b want sel 5 to 1", bus.sel, bus.timeout);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.sel !== 4'd5 || bus.timeout !== 1'b0)
      $display("FAIL timeout_one_cycle: got sel %0d to %b want sel 5 to 0", bus.sel, bus.timeout);
    else n_pass++;
  endtask

  task automatic test_drop();
    do_reset();
    bus.req = 16'h0084;
    tick();
    n_checks++;
    if (bus.sel !== 4'd2) $display("FAIL drop_first: got %0d want 2", bus.sel); else n_pass++;
    bus.req = 16'h0080;
    tick();
    n_checks++;
    if (bus.sel !== 4'd7 || bus.timeout !== 1'b0 || bus.grant !== 16'h0080)
      $display("FAIL drop_next: got sel %0d to %b grant %h want sel 7 to 0 grant 0080", bus.sel, bus.timeout, bus.grant);
    else n_pass++;
  endtask

  task automatic test_sole_wrap();
    do_reset();
    bus.req = 16'h8000;
    tick();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < MAX_HOLD - 1; i++) tick();
      tick();
      n_checks++;
      if (bus.sel !== 4'd15 || bus.timeout !== 1'b1 || bus.gnt_valid !== 1'b1)
        $display("FAIL sole_regrant_%0d: got sel %0d to %b valid %b want sel 15 to 1 valid 1", r, bus.sel, bus.timeout, bus.gnt_valid);
      else n_pass++;
    end
    bus.req = 16'h8001;
    for (int i = 0; i < MAX_HOLD - 1; i++) tick();
    tick();
    n_checks++;
    if (bus.sel !== 4'd0 || bus.timeout !== 1'b1)
      $display("FAIL wrap_to_zero: got sel %0d to %b want sel 0 to 1", bus.sel, bus.timeout);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req           = 16'hFFFF;
    bus.release_grant = 1'b1;
    tick();
    tick();
    tick();
    bus.release_grant = 1'b0;
    tick();
    tick();
    tick();
    n_checks++;
    if (bus.sel !== 4'd2) $display("FAIL reset_mid_pre: got %0d want 2", bus.sel); else n_pass++;
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (bus.grant !== 16'h0000 || bus.sel !== 4'd0 || bus.timeout !== 1'b0 || bus.gnt_valid !== 1'b0)
      $display("FAIL reset_mid_async: got grant %h sel %0d to %b valid %b want all zero", bus.grant, bus.sel, bus.timeout, bus.gnt_valid);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.sel !== 4'd0 || bus.grant !== 16'h0001)
      $display("FAIL reset_mid_first: got sel %0d grant %h want sel 0 grant 0001", bus.sel, bus.grant);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(7) == 0) bus.req = 16'($urandom);
      if ($urandom_range(15) == 0) bus.req = 16'(1 << $urandom_range(15));
      bus.release_grant = ($urandom_range(9) == 0);
      tick();
      n_checks++;
      if (bus.grant !== m_grant || bus.gnt_valid !== m_valid || bus.timeout !== m_to ||
          bus.sel !== 4'(m_sel))
        $display("FAIL random_%0d: got sel %0d grant %h valid %b to %b want sel %0d grant %h valid %b to %b",
                 c, bus.sel, bus.grant, bus.gnt_valid, bus.timeout, m_sel, m_grant, m_valid, m_to);
      else n_pass++;
    end
    bus.release_grant = 1'b0;
  endtask

  initial begin
    bus.req           = '0;
    bus.release_grant = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_drop();
    test_sole_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
